// File: rtl/onchip_mem_arb_pkg.sv
// Shared types and defaults for the two-master on-chip RAM arbiter.
// Default widths, the out-of-range read pattern, master ids and the read-return pipeline record.
package onchip_mem_arb_pkg;

  localparam int          DEF_ADDR_W   = 16;
  localparam int          DEF_DATA_W   = 32;
  localparam int          DEF_DEPTH    = 40000;
  localparam logic [31:0] DEF_ERR_DATA = 32'hDEADBEEF;

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } master_id_t;

  typedef struct packed {
    logic       valid;
    master_id_t owner;
    logic       oor;
  } rd_pipe_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-request round-robin arbiter with a registered last_grant and a one-hot grant output.
// While both masters request, the master that was not granted last is granted.
module rr_arb2
  import onchip_mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  master_id_t last_grant;

  // Grant is held off during reset so that neither master is accepted before the RAM is enabled.
  always_comb begin
    // NOTE: default assignment first, so every path drives grant and no latch is inferred.
    grant = 2'b00;
    if (!reset) begin
      if (req == 2'b11) grant = (last_grant == M0) ? 2'b10 : 2'b01;
      else              grant = req;
    end
  end

  // NOTE: non-blocking assignments for registered state, so all flops see pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         last_grant <= M1;
    else if (grant[1]) last_grant <= M1;
    else if (grant[0]) last_grant <= M0;
  end

endmodule

// File: rtl/onchip_mem_arbiter.sv
// Two-master Avalon-MM front end for a single-port on-chip RAM with 1-cycle read latency.
// Serialises requests round-robin, filters out-of-range words, and returns read data one cycle after acceptance.
module onchip_mem_arbiter
  import onchip_mem_arb_pkg::*;
#(
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter int                DATA_W   = DEF_DATA_W,
  parameter int                DEPTH    = DEF_DEPTH,
  parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(DEF_ERR_DATA)
) (
  input  logic                clk,
  input  logic                reset,

  input  logic [ADDR_W-1:0]   m0_address,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,

  input  logic [ADDR_W-1:0]   m1_address,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,

  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata,

  output logic                err_oor
);

  localparam int          BE_W    = DATA_W / 8;
  localparam logic [ADDR_W:0] DEPTH_W = DEPTH[ADDR_W:0];

  logic [1:0]        req;
  logic [1:0]        grant;
  logic              granted;
  master_id_t        sel_id;
  logic [ADDR_W-1:0] sel_addr;
  logic [BE_W-1:0]   sel_be;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_write;
  logic              sel_read;
  logic              sel_oor;
  logic              mem_access;
  rd_pipe_t          rd_pipe;
  logic [DATA_W-1:0] rd_data;

  assign req = {m1_read | m1_write, m0_read | m0_write};

  rr_arb2 u_rr_arb2 (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .grant (grant)
  );

  assign granted   = |grant;
  assign sel_id    = grant[1] ? M1 : M0;
  assign sel_addr  = (sel_id == M1) ? m1_address    : m0_address;
  assign sel_be    = (sel_id == M1) ? m1_byteenable : m0_byteenable;
  assign sel_wdata = (sel_id == M1) ? m1_writedata  : m0_writedata;
  assign sel_write = (sel_id == M1) ? m1_write      : m0_write;
  // A simultaneous read and write is treated as a write.
  assign sel_read  = ((sel_id == M1) ? m1_read : m0_read) & ~sel_write;
  assign sel_oor   = {1'b0, sel_addr} >= DEPTH_W;

  // Out-of-range requests are still accepted; they just never reach the RAM.
  assign mem_access     = granted & ~sel_oor;
  assign mem_chipselect = mem_access;
  assign mem_write      = mem_access & sel_write;
  assign mem_address    = mem_access ? sel_addr  : '0;
  assign mem_byteenable = mem_access ? sel_be    : '0;
  assign mem_writedata  = mem_access ? sel_wdata : '0;
  assign mem_clken      = ~reset;

  assign m0_waitrequest = reset | (req[0] & ~grant[0]);
  assign m1_waitrequest = reset | (req[1] & ~grant[1]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_pipe <= '{valid: 1'b0, owner: M0, oor: 1'b0};
    end else begin
      rd_pipe <= '{valid: granted & sel_read, owner: sel_id, oor: sel_oor};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  err_oor <= 1'b0;
    else if (granted & sel_oor) err_oor <= 1'b1;
  end

  assign rd_data          = rd_pipe.oor ? ERR_DATA : mem_readdata;
  assign m0_readdata      = rd_data;
  assign m1_readdata      = rd_data;
  assign m0_readdatavalid = rd_pipe.valid & (rd_pipe.owner == M0);
  assign m1_readdatavalid = rd_pipe.valid & (rd_pipe.owner == M1);

endmodule
